mem_access_ctrl: RTL and testbench

- Memory-access controller between the ALU result/store-data path and the word-wide, synchronous-read data RAM of the MEM stage.
- Adds byte and halfword loads with sign/zero extension, and byte/halfword stores done as read-modify-write over the 32-bit RAM.
- Raises a stall to the CPU until each access completes.

---
 rtl/mem_access_pkg.sv | 26 ++
 rtl/load_extract.sv | 30 +++
 rtl/mem_access_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage access controller: access-size codes,
// lane widths and the controller state type.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_RD_WAIT,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Size code 11 behaves as a word access.
  function automatic logic is_word(input logic [1:0] size);
    return (size == SIZE_WORD) || (size == 2'b11);
  endfunction

endpackage

// File: rtl/load_extract.sv
// Load lane selection with sign/zero extension (little-endian lanes).
//   word    : 32-bit word read from RAM
//   addr_lo : byte offset within the word
//   size    : access size code (byte / half / word)
//   sext    : 1 sign-extends, 0 zero-extends
//   result  : extended load value
module load_extract
  import mem_access_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              sext,
  output logic [WORD_W-1:0] result
);

  logic [BYTE_W-1:0] lane_b;
  logic [HALF_W-1:0] lane_h;

  always_comb begin
    lane_b = word[{addr_lo, 3'b000} +: BYTE_W];
    lane_h = addr_lo[1] ? word[WORD_W-1:HALF_W] : word[HALF_W-1:0];
    case (size)
      SIZE_BYTE: result = {{(WORD_W-BYTE_W){sext & lane_b[BYTE_W-1]}}, lane_b};
      SIZE_HALF: result = {{(WORD_W-HALF_W){sext & lane_h[HALF_W-1]}}, lane_h};
      default:   result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage memory-access controller: byte/half/word loads with extension,
// byte/half stores as read-modify-write over a synchronous-read word RAM.
//   clock, resetn      : clock, synchronous active-low reset
//   mem_req .. wdata   : CPU access request (held until stall drops)
//   rdata, stall, done : load result, pipeline freeze, completion pulse
//   misalign           : trap flag, present only with MEM_MISALIGN_TRAP_EN
//   ram_*              : word RAM interface (read data valid one cycle later)
// Optional feature macro: MEM_MISALIGN_TRAP_EN
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_size,
  input  logic                  mem_sext,
  input  logic [WORD_W-1:0]     addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata,
  output logic                  stall,
  output logic                  done,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                  misalign,
`endif
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_W-1:0]     ram_din,
  output logic                  ram_we,
  input  logic [WORD_W-1:0]     ram_dout
);

  localparam int unsigned AW = ADDR_WIDTH + 2;

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;
  logic              sext_q, sext_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [WORD_W-1:0] merge_q, merge_d;
  logic [WORD_W-1:0] load_val;
  logic [WORD_W-1:0] merged;

  // Byte address bits above the RAM range are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[WORD_W-1:AW];

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic req_mis;
  assign req_mis = ((mem_size == SIZE_HALF) && addr[0]) ||
                   (is_word(mem_size) && (addr[1:0] != 2'b00));
  assign misalign = mis_q;
`endif

  load_extract u_load_extract (
    .word    (ram_dout),
    .addr_lo (addr_q[1:0]),
    .size    (size_q),
    .sext    (sext_q),
    .result  (load_val)
  );

  always_comb begin
    merged = ram_dout;
    if (size_q == SIZE_BYTE) begin
      merged[{addr_q[1:0], 3'b000} +: BYTE_W] = wdata_q[BYTE_W-1:0];
    end else if (size_q == SIZE_HALF) begin
      merged[{addr_q[1], 4'b0000} +: HALF_W] = wdata_q[HALF_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    we_d    = we_q;
    sext_d  = sext_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          addr_d  = addr[AW-1:0];
          wdata_d = wdata;
          size_d  = mem_size;
          we_d    = mem_we;
          sext_d  = mem_sext;
          if (mem_we && is_word(mem_size)) state_d = ST_WRITE;
          else                             state_d = ST_READ;
`ifdef MEM_MISALIGN_TRAP_EN
          if (req_mis) begin
            state_d = ST_DONE;
            mis_d   = 1'b1;
          end
`endif
        end
      end
      ST_READ:    state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (we_q) begin
          merge_d = merged;
          state_d = ST_WRITE;
        end else begin
          rdata_d = load_val;
          state_d = ST_DONE;
        end
      end
      ST_WRITE:   state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      rdata_q <= '0;
      merge_q <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      we_q    <= we_d;
      sext_q  <= sext_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign rdata    = rdata_q;
  assign done     = (state_q == ST_DONE);
  assign stall    = mem_req & (state_q != ST_DONE);
  assign ram_we   = (state_q == ST_WRITE);
  assign ram_addr = addr_q[AW-1:2];
  assign ram_din  = is_word(size_q) ? wdata_q : merge_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clock;
  logic        resetn;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [31:0] ram_dout;

  mem_access_ctrl #(.ADDR_WIDTH(10)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_size (mem_size),
    .mem_sext (mem_sext),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .done     (done),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign (misalign),
`endif
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Word RAM attached to the DUT, and the reference image the model keeps.
  logic [31:0] ram     [1024];
  logic [31:0] ref_mem [1024];
  bit          ram_loaded;
  int unsigned we_cnt;

  always @(posedge clock) begin
    if (!ram_loaded) begin
      for (int unsigned i = 0; i < 1024; i++) ram[i] <= ref_mem[i];
      ram_loaded <= 1'b1;
    end else if (ram_we === 1'b1) begin
      ram[ram_addr] <= ram_din;
    end
    ram_dout <= ram[ram_addr];
    if (ram_we === 1'b1) we_cnt <= we_cnt + 1;
  end

  int unsigned n_checks;
  int unsigned n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expectations of the transaction currently in flight.
  bit          active;
  bit          quiet;
  int unsigned k;
  int unsigned lat;
  bit          exp_store;
  bit          is_load;
  bit          exp_mis;
  bit          seen_done;
  bit          mis_seen;
  logic [9:0]  exp_waddr;
  logic [31:0] exp_din;
  logic [31:0] exp_rdata;
  logic [31:0] last_rdata;

  always @(negedge clock) begin
    if (!quiet && resetn) begin
      if (active) begin
        if (is_load && k == lat) last_rdata = exp_rdata;
        check("stall", stall, mem_req && (k < lat));
        check("done", done, k == lat);
        check("ram_we", ram_we, exp_store && (k + 1 == lat));
        if (exp_store && (k + 1 == lat)) begin
          check("ram_addr", ram_addr, exp_waddr);
          check("ram_din", ram_din, exp_din);
        end
        check("rdata", rdata, last_rdata);
`ifdef MEM_MISALIGN_TRAP_EN
        check("misalign", misalign, exp_mis && (k == lat));
        if (misalign === 1'b1) mis_seen = 1'b1;
`endif
        if (done === 1'b1) seen_done = 1'b1;
        if (k >= lat) active = 1'b0;
        else k++;
      end else begin
        check("idle_stall", stall, 0);
        check("idle_done", done, 0);
        check("idle_ram_we", ram_we, 0);
        check("idle_rdata", rdata, last_rdata);
`ifdef MEM_MISALIGN_TRAP_EN
        check("idle_misalign", misalign, 0);
`endif
      end
    end
  end

  // Issues one access starting in the current cycle (called #1 after a rising edge)
  // and returns #1 after the rising edge that ends the DONE cycle.
  task automatic access(input bit we, input logic [1:0] sz_in, input bit sext,
                        input logic [31:0] a, input logic [31:0] wd, input bit scramble);
    int unsigned sz;
    int unsigned sh;
    logic [9:0]  idx;
    logic [31:0] old, lane, mask, nw;
    sz = (sz_in == 2'd3) ? 2 : sz_in;
    idx = a[11:2];
    old = ref_mem[idx];
    exp_mis = 1'b0;
    exp_store = 1'b0;
    is_load = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    exp_mis = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
`endif
    if (exp_mis) begin
      lat = 1;
    end else if (!we) begin
      lat = 3;
      is_load = 1'b1;
      if (sz == 0) begin
        lane = (old >> (8 * a[1:0])) & 32'hFF;
        if (sext && lane[7]) lane = lane | 32'hFFFF_FF00;
      end else if (sz == 1) begin
        lane = (old >> (a[1] ? 16 : 0)) & 32'hFFFF;
        if (sext && lane[15]) lane = lane | 32'hFFFF_0000;
      end else begin
        lane = old;
      end
      exp_rdata = lane;
    end else begin
      exp_store = 1'b1;
      exp_waddr = idx;
      if (sz == 2) begin
        lat = 2;
        nw = wd;
      end else begin
        lat = 4;
        sh = (sz == 0) ? 8 * a[1:0] : (a[1] ? 16 : 0);
        mask = ((sz == 0) ? 32'hFF : 32'hFFFF) << sh;
        nw = (old & ~mask) | ((wd << sh) & mask);
      end
      exp_din = nw;
      ref_mem[idx] = nw;
    end
    mem_we = we; mem_size = sz_in; mem_sext = sext; addr = a; wdata = wd;
    mem_req = 1'b1;
    k = 0;
    seen_done = 1'b0;
    active = 1'b1;
    if (scramble) begin
      @(posedge clock);
      #1;
      addr = $urandom; wdata = $urandom; mem_size = 2'($urandom);
      mem_we = 1'($urandom); mem_sext = 1'($urandom); mem_req = 1'($urandom);
    end
    for (int unsigned c = 0; c < 8 && !seen_done; c++) @(posedge clock);
    if (!seen_done) begin
      check("done_timeout", 0, 1);
      active = 1'b0;
    end
    #1;
    mem_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    int unsigned bad;
    logic [9:0]  idx;
    logic [31:0] a;
    for (int unsigned i = 0; i < 1024; i++) ref_mem[i] = $urandom;
    quiet = 1'b1; active = 1'b0; last_rdata = '0;
    resetn = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_size = '0; mem_sext = 1'b0;
    addr = '0; wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_rdata", rdata, 0);
    check("reset_done", done, 0);
    check("reset_stall", stall, 0);
    check("reset_ram_we", ram_we, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    check("reset_misalign", misalign, 0);
`endif
    resetn = 1'b1;
    quiet = 1'b0;

    // Word store, byte loads, byte store RMW, halfword store + load.
    access(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
    check("t1_ram4", ram[4], 32'hDEADBEEF);
    access(0, 2'b00, 1, 32'h13, 32'h0, 0);
    check("t2_sext", rdata, 32'hFFFF_FFDE);
    access(0, 2'b00, 0, 32'h13, 32'h0, 0);
    check("t2_zext", rdata, 32'h0000_00DE);
    access(1, 2'b00, 0, 32'h11, 32'h55, 0);
    check("t3_ram4", ram[4], 32'hDEAD55EF);
    access(0, 2'b10, 0, 32'h10, 32'h0, 0);
    check("t3_load", rdata, 32'hDEAD55EF);
    access(1, 2'b01, 0, 32'h12, 32'h1234_8001, 0);
    access(0, 2'b01, 1, 32'h12, 32'h0, 0);
    check("t4_half", rdata, 32'hFFFF_8001);

    // Reset during RD_WAIT of a byte store to word 5.
    quiet = 1'b1;
    base = we_cnt;
    mem_we = 1'b1; mem_size = 2'b00; mem_sext = 1'b0; addr = 32'h14; wdata = 32'hA5;
    mem_req = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1 resetn = 1'b0;
    @(posedge clock);
    #1 resetn = 1'b1;
    mem_req = 1'b0;
    check("t5_rdata", rdata, 0);
    check("t5_done", done, 0);
    check("t5_ram_we", ram_we, 0);
    last_rdata = '0;
    quiet = 1'b0;
    access(0, 2'b10, 0, 32'h14, 32'h0, 0);
    check("t5_no_write", we_cnt - base, 0);
    check("t5_word", ram[5], ref_mem[5]);

`ifdef MEM_MISALIGN_TRAP_EN
    access(0, 2'b10, 0, 32'h0, 32'h0, 0);
    mis_seen = 1'b0;
    access(0, 2'b10, 0, 32'h2, 32'h0, 0);
    check("t6_misalign", mis_seen, 1);
`endif

    // Randomised traffic, including wrap-around words and mid-access input changes.
    for (int unsigned i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
      idx = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 7)) : 10'(1016 + $urandom_range(0, 7));
      a = $urandom;
      a[11:2] = idx;
      access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, 3) == 0);
    end

    repeat (2) @(posedge clock);
    bad = 0;
    for (int unsigned i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) bad++;
    check("ram_final_mismatches", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
